// File: rtl/pwm_multi.sv
// Multi-channel PWM: one prescaled period counter shared by all channels, with duty values
// shadowed and swapped in at the period boundary. Define PWM_MULTI_CENTER_ALIGN_EN for up/down counting.
module pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 8,
  parameter int PRESC_W    = 8,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   period,
  input  logic               duty_wr,
  input  logic [CH_W-1:0]    duty_ch,
  input  logic [WIDTH-1:0]   duty_data,
`ifdef PWM_MULTI_CENTER_ALIGN_EN
  input  logic               center_mode,
`endif
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_tick,
  output logic [WIDTH-1:0]   cnt
);

  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   act_period;
  logic [WIDTH-1:0]   shadow   [NUM_CH];
  logic [WIDTH-1:0]   act_duty [NUM_CH];
  logic [WIDTH-1:0]   cnt_next;
  logic [NUM_CH-1:0]  active;
  logic               tick;
  logic               update;

  assign tick        = enable && (presc == prescale);
  assign period_tick = update;

`ifdef PWM_MULTI_CENTER_ALIGN_EN
  logic down;
  logic down_next;
  logic mode_act;

  always_comb begin
    cnt_next  = cnt + 1'b1;
    down_next = down;
    update    = 1'b0;
    if (mode_act) begin
      update = tick && down && (cnt == '0);
      if (down) begin
        // Valley: restart the up-ramp against the period being loaded right now.
        if (cnt == '0) begin
          if (period == '0) begin
            cnt_next  = '0;
            down_next = 1'b1;
          end else begin
            cnt_next  = WIDTH'(1);
            down_next = 1'b0;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end else if (cnt >= act_period) begin
        cnt_next  = (cnt == '0) ? '0 : cnt - 1'b1;
        down_next = 1'b1;
      end
    end else begin
      update = tick && (cnt == act_period);
      if (cnt == act_period) begin
        cnt_next  = '0;
        down_next = 1'b0;
      end
    end
  end

  // Down flag parks high while idle so the first tick after enable is a valley update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down     <= 1'b1;
      mode_act <= 1'b0;
    end else if (!enable) begin
      down     <= 1'b1;
      mode_act <= center_mode;
    end else begin
      if (tick)   down     <= down_next;
      if (update) mode_act <= center_mode;
    end
  end
`else
  always_comb begin
    update   = tick && (cnt == act_period);
    cnt_next = (cnt == act_period) ? '0 : cnt + 1'b1;
  end
`endif

  // Prescaler wraps through its full range if prescale is lowered beneath it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                presc <= '0;
    else if (!enable || tick)  presc <= '0;
    else                       presc <= presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      act_period <= '1;
      for (int i = 0; i < NUM_CH; i++) act_duty[i] <= '0;
    end else if (!enable) begin
      cnt        <= '0;
      act_period <= period;
      for (int i = 0; i < NUM_CH; i++) act_duty[i] <= shadow[i];
    end else begin
      if (tick) cnt <= cnt_next;
      if (update) begin
        act_period <= period;
        for (int i = 0; i < NUM_CH; i++) act_duty[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (duty_wr && (duty_ch == CH_W'(i))) shadow[i] <= duty_data;
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_CH; i++) active[i] = (cnt < act_duty[i]);
  end

  // Output register stage: compare of this cycle's cnt appears on the pins next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pwm_out <= {NUM_CH{ACTIVE_LOW}};
    else if (enable)  pwm_out <= active ^ {NUM_CH{ACTIVE_LOW}};
    else              pwm_out <= {NUM_CH{ACTIVE_LOW}};
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios plus randomized traffic against a cycle reference model.
module tb_pwm_multi;
  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 8;
  localparam int PRESC_W = 8;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int CH_W    = 2;
  localparam logic ACT   = !ACTIVE_LOW;
  localparam logic [NUM_CH-1:0] IDLE = {NUM_CH{ACTIVE_LOW}};

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [PRESC_W-1:0] prescale;
  logic [WIDTH-1:0]   period;
  logic               duty_wr;
  logic [CH_W-1:0]    duty_ch;
  logic [WIDTH-1:0]   duty_data;
  logic [NUM_CH-1:0]  pwm_out;
  logic               period_tick;
  logic [WIDTH-1:0]   cnt;
`ifdef PWM_MULTI_CENTER_ALIGN_EN
  logic               center_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  pwm_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_W(PRESC_W), .ACTIVE_LOW(ACTIVE_LOW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale), .period(period),
    .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_data(duty_data),
`ifdef PWM_MULTI_CENTER_ALIGN_EN
    .center_mode(center_mode),
`endif
    .pwm_out(pwm_out), .period_tick(period_tick), .cnt(cnt)
  );

  int nvec  = 0;
  int nfail = 0;

  // Reference model state, in plain integers.
  int m_pre, m_cnt, m_per;
  int m_sh  [NUM_CH];
  int m_act [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;
  int win_act [NUM_CH];
  int win_ticks;

  function automatic bit exp_tick();
    return enable && (m_pre == int'(prescale)) && (m_cnt == m_per);
  endfunction

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_per = (1 << WIDTH) - 1; m_pwm = IDLE;
    for (int i = 0; i < NUM_CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] np;
    bit tk, up;
    tk = enable && (m_pre == int'(prescale));
    up = tk && (m_cnt == m_per);
    for (int i = 0; i < NUM_CH; i++) np[i] = (enable && m_cnt < m_act[i]) ? ACT : ACTIVE_LOW;
    if (!enable) begin
      m_pre = 0; m_cnt = 0; m_per = int'(period);
      for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
    end else if (tk) begin
      m_pre = 0;
      if (up) begin
        m_cnt = 0; m_per = int'(period);
        for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_pre = (m_pre + 1) % (1 << PRESC_W);
    end
    if (duty_wr && int'(duty_ch) < NUM_CH) m_sh[duty_ch] = int'(duty_data);
    m_pwm = np;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input int ch, input int val);
    duty_wr = 1'b1; duty_ch = CH_W'(ch); duty_data = WIDTH'(val);
    cycle();
    duty_wr = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      cycle();
      if (period_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic count_window();
    win_ticks = 0;
    for (int i = 0; i < NUM_CH; i++) win_act[i] = 0;
    repeat (10) begin
      cycle();
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i] === ACT) win_act[i]++;
      if (period_tick === 1'b1) win_ticks++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; prescale = '0; period = 8'd9;
    duty_wr = 1'b0; duty_ch = '0; duty_data = '0;
    model_reset();
    #12;
    nvec++; if (pwm_out !== IDLE) begin nfail++; $display("FAIL reset_pwm: got %b want %b", pwm_out, IDLE); end
    nvec++; if (cnt !== '0) begin nfail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    nvec++; if (period_tick !== 1'b0) begin nfail++; $display("FAIL reset_tick: got %b want 0", period_tick); end
    rst_n = 1'b1;
    repeat (3) begin
      cycle();
      nvec++;
      if (pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
        nfail++;
        $display("FAIL reset_idle: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
                 pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
      end
    end
  endtask

  task automatic test_edge_basic();
    int exp_on [NUM_CH] = '{0, 3, 10, 5};
    bit ok;
    enable = 1'b0; period = 8'd9; prescale = '0;
    for (int i = 0; i < NUM_CH; i++) write_duty(i, exp_on[i]);
    cycle();
    enable = 1'b1;
    repeat (15) begin
      cycle();
      nvec++;
      if (pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
        nfail++;
        $display("FAIL edge_cycle: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
                 pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
      end
    end
    wait_tick(30, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL edge_wait_tick: got none want tick within 30"); end
    cycle();
    count_window();
    for (int i = 0; i < NUM_CH; i++) begin
      nvec++;
      if (win_act[i] != exp_on[i]) begin
        nfail++; $display("FAIL edge_duty ch%0d: got %0d active want %0d", i, win_act[i], exp_on[i]);
      end
    end
    nvec++; if (win_ticks != 1) begin nfail++; $display("FAIL edge_ticks: got %0d want 1", win_ticks); end
  endtask

  task automatic test_shadow();
    bit ok;
    repeat (4) cycle();
    write_duty(1, 7);
    wait_tick(20, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL shadow_wait1: got none want tick"); end
    cycle();
    count_window();
    nvec++; if (win_act[1] != 7) begin nfail++; $display("FAIL shadow_mid: got %0d want 7", win_act[1]); end
    wait_tick(20, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL shadow_wait2: got none want tick"); end
    write_duty(1, 2);
    count_window();
    nvec++; if (win_act[1] != 7) begin nfail++; $display("FAIL shadow_tickwr_old: got %0d want 7", win_act[1]); end
    count_window();
    nvec++; if (win_act[1] != 2) begin nfail++; $display("FAIL shadow_tickwr_new: got %0d want 2", win_act[1]); end
  endtask

  task automatic test_prescaler();
    bit ok;
    int gap;
    enable = 1'b0; cycle();
    prescale = 8'd2; period = 8'd3; enable = 1'b1;
    repeat (30) begin
      cycle();
      nvec++;
      if (pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
        nfail++;
        $display("FAIL presc_cycle: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
                 pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
      end
    end
    wait_tick(40, ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL presc_wait: got none want tick"); end
    gap = 0;
    do begin cycle(); gap++; end while (period_tick !== 1'b1 && gap < 40);
    nvec++; if (gap != 12) begin nfail++; $display("FAIL presc_spacing: got %0d want 12", gap); end
  endtask

  task automatic test_presc_wrap();
    enable = 1'b0; cycle();
    prescale = 8'd5; period = 8'd9; enable = 1'b1;
    repeat (4) cycle();
    prescale = 8'd1;
    repeat (254) begin
      cycle();
      nvec++;
      if (pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
        nfail++;
        $display("FAIL wrap_cycle: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
                 pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
      end
    end
    nvec++; if (cnt !== 8'd1) begin nfail++; $display("FAIL wrap_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_enable();
    int exp_on [NUM_CH] = '{2, 4, 6, 8};
    enable = 1'b0; cycle();
    prescale = '0; period = 8'd9; enable = 1'b1;
    repeat (5) cycle();
    enable = 1'b0;
    cycle();
    nvec++; if (pwm_out !== IDLE) begin nfail++; $display("FAIL en_off_pwm: got %b want %b", pwm_out, IDLE); end
    nvec++; if (cnt !== '0) begin nfail++; $display("FAIL en_off_cnt: got %0d want 0", cnt); end
    for (int i = 0; i < NUM_CH; i++) write_duty(i, exp_on[i]);
    cycle();
    nvec++;
    if (pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
      nfail++;
      $display("FAIL en_idle: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
               pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
    end
    enable = 1'b1;
    nvec++;
    if (cnt !== '0 || period_tick !== 1'b0) begin
      nfail++; $display("FAIL en_restart: cnt=%0d tick=%b want cnt=0 tick=0", cnt, period_tick);
    end
    count_window();
    for (int i = 0; i < NUM_CH; i++) begin
      nvec++;
      if (win_act[i] != exp_on[i]) begin
        nfail++; $display("FAIL en_duty ch%0d: got %0d active want %0d", i, win_act[i], exp_on[i]);
      end
    end
  endtask

  task automatic test_period_zero();
    int d [NUM_CH] = '{0, 1, 5, 0};
    enable = 1'b0; period = '0; prescale = '0;
    for (int i = 0; i < NUM_CH; i++) write_duty(i, d[i]);
    cycle();
    enable = 1'b1;
    repeat (8) begin
      cycle();
      nvec++;
      if (pwm_out !== m_pwm || cnt !== '0 || period_tick !== 1'b1) begin
        nfail++;
        $display("FAIL pzero_cycle: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=0 tick=1",
                 pwm_out, cnt, period_tick, m_pwm);
      end
    end
    nvec++; if (pwm_out !== 4'b1001) begin nfail++; $display("FAIL pzero_pwm: got %b want 1001", pwm_out); end
  endtask

  task automatic test_reset_mid();
    int d [NUM_CH] = '{3, 5, 7, 9};
    enable = 1'b0; period = 8'd9; prescale = '0;
    for (int i = 0; i < NUM_CH; i++) write_duty(i, d[i]);
    cycle();
    enable = 1'b1;
    repeat (4) cycle();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    nvec++; if (pwm_out !== IDLE) begin nfail++; $display("FAIL rmid_pwm: got %b want %b", pwm_out, IDLE); end
    nvec++; if (cnt !== '0) begin nfail++; $display("FAIL rmid_cnt: got %0d want 0", cnt); end
    nvec++; if (period_tick !== 1'b0) begin nfail++; $display("FAIL rmid_tick: got %b want 0", period_tick); end
    #2 rst_n = 1'b1;
    repeat (20) begin
      cycle();
      nvec++;
      if (pwm_out !== IDLE || pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
        nfail++;
        $display("FAIL rmid_after: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
                 pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
      end
    end
  endtask

  task automatic test_random();
    enable = 1'b1; prescale = 8'd1; period = 8'd7;
    for (int n = 0; n < 800; n++) begin
      duty_wr   = ($urandom_range(0, 3) == 0);
      duty_ch   = CH_W'($urandom);
      duty_data = WIDTH'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) prescale = PRESC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) period = WIDTH'($urandom_range(0, 15));
      cycle();
      nvec++;
      if (pwm_out !== m_pwm || cnt !== WIDTH'(m_cnt) || period_tick !== exp_tick()) begin
        nfail++;
        $display("FAIL rand_%0d: pwm=%b cnt=%0d tick=%b want pwm=%b cnt=%0d tick=%b",
                 n, pwm_out, cnt, period_tick, m_pwm, m_cnt, exp_tick());
      end
    end
    duty_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_shadow();
    test_prescaler();
    test_presc_wrap();
    test_enable();
    test_period_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
